// File: rtl/theme_ui_pkg.sv
// -----------------------------------------------------------------------------
// theme_ui_pkg
// Shared definitions for the VGA theme user-interface blocks:
//   - btn_state_e : debounce FSM state encoding
//   - DEF_*       : default debounce / auto-repeat timing (100 MHz clock)
//   - THEME_COUNT : number of themes the theme controller cycles through
//   - max3()      : constant helper used to size shared counters
// -----------------------------------------------------------------------------
package theme_ui_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

  // 10 ms debounce, 500 ms before first repeat, 200 ms between repeats
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
  localparam int unsigned DEF_HOLD_CYCLES     = 32'd50000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 32'd20000000;

  localparam int unsigned THEME_COUNT = 32'd3;

  // Largest of three values; elaboration-time sizing helper.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/theme_btn_debounce_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk : destination clock
//   rst : asynchronous reset, active-high, clears both stages to 0
//   d   : asynchronous input
//   q   : synchronized output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Next-value selection for the two synchronizer stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/theme_btn_debounce.sv
// -----------------------------------------------------------------------------
// theme_btn_debounce
// Conditions the raw theme pushbutton into a clean single-cycle change pulse
// for the theme controller and exports the debounced button level.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous reset, active-high
//   btn       : raw pushbutton, asynchronous, active-high
//   chg       : one-cycle change pulse per accepted press (registered)
//   btn_level : debounced level (1 in HELD / REL_CHK)
//   busy      : high while a press or release is being qualified
//
// Build option:
//   AUTO_REPEAT_EN : when defined, holding the button produces a repeat
//                    pulse after HOLD_CYCLES, then every REPEAT_CYCLES.
// -----------------------------------------------------------------------------
module theme_btn_debounce
  import theme_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic chg,
  output logic btn_level,
  output logic busy
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 32'd1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] DEB_W    = CW'(DEBOUNCE_CYCLES);

  logic       s2;
  btn_state_e state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [CW-1:0] cnt_inc;
  logic       chg_d, chg_q;
  logic       btn_level_d, btn_level_q;
  logic       busy_d, busy_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] HOLD_W = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_W  = CW'(REPEAT_CYCLES);

  logic [CW-1:0] hold_cnt_d, hold_cnt_q;
  logic [CW-1:0] hold_inc;
  logic          rep_mode_d, rep_mode_q;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (s2)
  );

  // Saturating increments; counters never wrap back to zero.
  always_comb begin
    if (cnt_q == CNT_SAT) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + CNT_ONE;
    end
`ifdef AUTO_REPEAT_EN
    if (hold_cnt_q == CNT_SAT) begin
      hold_inc = hold_cnt_q;
    end else begin
      hold_inc = hold_cnt_q + CNT_ONE;
    end
`endif
  end

  // Debounce FSM next-state, counter and output decode.
  // The sample that moves the FSM out of IDLE/HELD already counts as the
  // first stable sample, so a press is accepted on the DEBOUNCE_CYCLES-th
  // consecutive high sample (immediately when DEBOUNCE_CYCLES is 1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
    hold_cnt_d = hold_cnt_q;
    rep_mode_d = rep_mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2) begin
          if (CNT_ONE >= DEB_W) begin
            state_d = HELD;
            cnt_d   = CNT_ZERO;
            chg_d   = 1'b1;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_inc >= DEB_W) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
          chg_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!s2) begin
          if (CNT_ONE >= DEB_W) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = REL_CHK;
            cnt_d   = CNT_ONE;
          end
        end else begin
`ifdef AUTO_REPEAT_EN
          // First pulse after HOLD_CYCLES, then every REPEAT_CYCLES.
          if (hold_inc >= (rep_mode_q ? REP_W : HOLD_W)) begin
            chg_d      = 1'b1;
            hold_cnt_d = CNT_ZERO;
            rep_mode_d = 1'b1;
          end else begin
            hold_cnt_d = hold_inc;
          end
`else
          cnt_d = CNT_ZERO;
`endif
        end
      end
      REL_CHK: begin
        // Hold counter is left untouched here so a release bounce only
        // pauses the auto-repeat timing.
        if (s2) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_inc >= DEB_W) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

`ifdef AUTO_REPEAT_EN
    // Any path out of the held region restarts repeat timing from scratch.
    if ((state_d == IDLE) || (state_d == PRESS_CHK)) begin
      hold_cnt_d = CNT_ZERO;
      rep_mode_d = 1'b0;
    end else begin
      hold_cnt_d = hold_cnt_d;
      rep_mode_d = rep_mode_d;
    end
`endif

    btn_level_d = (state_d == HELD) || (state_d == REL_CHK);
    busy_d      = (state_d == PRESS_CHK) || (state_d == REL_CHK);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      chg_q       <= 1'b0;
      btn_level_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chg_q       <= chg_d;
      btn_level_q <= btn_level_d;
      busy_q      <= busy_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  // Auto-repeat hold timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= CNT_ZERO;
      rep_mode_q <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      rep_mode_q <= rep_mode_d;
    end
  end
`endif

  assign chg       = chg_q;
  assign btn_level = btn_level_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_theme_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_theme_btn_debounce
// Self-checking bench for theme_btn_debounce (DEBOUNCE=4, HOLD=10, REPEAT=5).
// Reference model: the button is delayed two samples, then the debounced
// level flips after DEBOUNCE consecutive samples that disagree with it.
// With AUTO_REPEAT_EN, time spent steadily high after acceptance is counted
// and pulses are expected at HOLD, HOLD+REPEAT, HOLD+2*REPEAT, ...
// -----------------------------------------------------------------------------
module tb_theme_btn_debounce;
  import theme_ui_pkg::*;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic chg, btn_level, busy;

  int checks   = 0;
  int failures = 0;

  // model state
  logic sy1_m, sy2_m, level_m, chg_m;
  int   run_m, age_m;

  // observation helpers
  int edge_n, first_chg_edge, pulses_dut;
  int theme;

  theme_btn_debounce #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .chg       (chg),
    .btn_level (btn_level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sy1_m = 1'b0; sy2_m = 1'b0; level_m = 1'b0; chg_m = 1'b0;
    run_m = 0; age_m = 0;
  endtask

  // Reference model step for one clock edge; btn value b is captured.
  task automatic model_edge(input logic b);
    logic smp;
    smp   = sy2_m;
    chg_m = 1'b0;
    if (smp != level_m) begin
      run_m++;
      if (run_m >= D) begin
        level_m = smp;
        run_m   = 0;
        chg_m   = smp;
        age_m   = 0;
      end
    end else begin
`ifdef AUTO_REPEAT_EN
      if (level_m && run_m == 0) begin
        age_m++;
        if (age_m >= H && ((age_m - H) % R) == 0) chg_m = 1'b1;
      end
`endif
      run_m = 0;
    end
    sy2_m = sy1_m;
    sy1_m = b;
  endtask

  // Apply one btn value for one clock and check all outputs against the model.
  task automatic cycle(input logic b);
    btn = b;
    @(posedge clk);
    model_edge(b);
    #1;
    edge_n++;
    check_val("chg", chg, chg_m);
    check_val("btn_level", btn_level, level_m);
    check_val("busy", busy, (run_m > 0));
    if (chg) begin
      pulses_dut++;
      theme = (theme + 1) % THEME_COUNT;
      if (first_chg_edge == 0) first_chg_edge = edge_n;
    end
  endtask

  task automatic start_window();
    edge_n = 0; first_chg_edge = 0; pulses_dut = 0;
  endtask

  task automatic settle_low();
    for (int i = 0; i < D + 6; i++) cycle(1'b0);
  endtask

  initial begin
    int len;
    logic lvl;
    btn = 1'b0;
    rst = 1'b1;
    theme = 0;
    model_reset();
    start_window();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_chg", chg, 1'b0);
    check_val("reset_level", btn_level, 1'b0);
    check_val("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Clean press: chg after edge D+2, exactly one pulse (no auto-repeat within 20).
    start_window();
    for (int i = 0; i < 20; i++) cycle(1'b1);
    check_val("press_latency", first_chg_edge, D + 2);
`ifndef AUTO_REPEAT_EN
    check_val("press_pulses", pulses_dut, 1);
`endif
    check_val("press_level", btn_level, 1'b1);
    settle_low();

    // Press bounce: 3 high, 2 low, 3 high -> never accepted.
    start_window();
    for (int i = 0; i < 3; i++) cycle(1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    settle_low();
    check_val("bounce_pulses", pulses_dut, 0);
    check_val("bounce_level", btn_level, 1'b0);

    // Release bounce: accepted press, 2 low, high again -> no second pulse.
    start_window();
    for (int i = 0; i < 8; i++) cycle(1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check_val("relbounce_pulses", pulses_dut, 1);
    check_val("relbounce_level", btn_level, 1'b1);
    settle_low();

    // Three full press/release cycles advance the theme 0,1,2,0.
    theme = 0;
    start_window();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) cycle(1'b1);
      check_val("theme_step", theme, (p + 1) % THEME_COUNT);
      settle_low();
    end
    check_val("theme_final", theme, 0);
    check_val("theme_pulses", pulses_dut, 3);

    // Reset in PRESS_CHK with count 3: outputs clear at once, no pulse;
    // button still high afterwards gives one pulse 6 edges later.
    start_window();
    for (int i = 0; i < 10 && run_m < 3; i++) cycle(1'b1);
    check_val("pre_reset_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_async_chg", chg, 1'b0);
    check_val("rst_async_level", btn_level, 1'b0);
    check_val("rst_async_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    start_window();
    for (int i = 0; i < 9; i++) cycle(1'b1);
    check_val("post_reset_latency", first_chg_edge, D + 2);
    check_val("post_reset_pulses", pulses_dut, 1);
    settle_low();

`ifdef AUTO_REPEAT_EN
    // Held 40 cycles: pulses at entry, +10, +15, +20, +25, +30, +35.
    start_window();
    for (int i = 0; i < 40; i++) cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    check_val("repeat_pulses", pulses_dut, 7);
    start_window();
    settle_low();
    check_val("repeat_after_release", pulses_dut, 0);
`endif

    // Randomized segments of varying length and level.
    for (int s = 0; s < 60; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 7));
      for (int i = 0; i < len; i++) cycle(lvl);
    end
    settle_low();
    check_val("random_end_level", btn_level, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
